seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Multicycle shift unit; consumes the 6-bit shift amount produced by the datapath's shift-amount selector (register field, constant 16, register value, or immediate).
- Shifts a 32-bit operand one bit per clock under control-unit handshake (start/busy/done).
- Result feeds the register-file write-data selector.
- Replaces a combinational barrel shifter so the control FSM sequences shifts like the other multicycle units.

Parameters:
- DATA_W, 32, operand/result width.
- SHAMT_W, 6, shift-amount width; matches the selector output.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation code, captured with start.
- shamt  input  SHAMT_W  shift amount, captured with start.
- data_in  input  DATA_W  operand, captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse, result valid.
- data_out  output  DATA_W  result; holds until the next accepted start.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, data_out=0, internal count=0, captured op=0.
- Op codes:
  - 000 PASS
  - 001 SLL: zero fill
  - 010 SRL: zero fill
  - 011 SRA: replicate bit 31
  - 100 ROL
  - 101 ROR
  - 110 and 111: treated as PASS.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E: capture data_in into the working register, plus op and shamt.
  - If shamt==0 or op is PASS: go to DONE.
  - Otherwise: count=shamt, go to SHIFT.
- SHIFT: at each edge, shift the working register one bit per op and decrement count; when count reaches 1, perform the final shift and go to DONE.
- DONE: done=1 for exactly one cycle, data_out=working register; next edge returns to IDLE.
- Latency: done is high in the cycle after edge E+max(shamt,0) for shift ops.
  - Example: shamt=3 gives done after edge E+3.
  - shamt=0 or PASS gives done after edge E.
- start while in SHIFT or DONE is ignored, not queued; a start arriving in the DONE cycle is lost. The control FSM waits for IDLE.
- Inputs may change freely after capture; the operation uses captured values only.
- Large amounts: shamt range is 0..63, no saturation logic; iterate the full count.
  - SLL/SRL with shamt>=32: result 0.
  - SRA with shamt>=32: result all sign bits.
  - Rotates are effectively modulo 32 (e.g. ROL 33 == ROL 1).
- data_out updates only on entry to DONE; it is stable during SHIFT (previous result visible).
- Reset asserted mid-SHIFT: immediate abort to the reset values above; no done pulse.
- busy and done are never high simultaneously.

Decomposition:
- Package shifter_pkg:
  - DATA_W, SHAMT_W constants.
  - op code localparams: OP_PASS, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR.
  - State encoding: ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- Sub-module shift_step (combinational): one-bit shift/rotate of a DATA_W word by op.
  - Instantiated once in the SHIFT datapath.
  - Unit-testable in isolation.

Test Plan:
- SLL: start, op=001, shamt=4, data_in=32'h0000_00F1 -> busy high 4 cycles; done pulse after edge E+4; data_out=32'h0000_0F10.
- SRA: op=011, shamt=16, data_in=32'h8000_1234 -> data_out=32'hFFFF_8000; done exactly 16 edges after capture.
- SRL: op=010, shamt=40, data_in=32'hFFFF_FFFF -> data_out=0.
- ROR: op=101, shamt=33, data_in=32'h0000_0001 -> data_out=32'h8000_0000.
- shamt=0 and op=111 cases: data_in=32'hDEAD_BEEF -> busy never asserted; done after edge E; data_out=32'hDEAD_BEEF.
- Reset mid-SHIFT: reset pulled low 2 cycles into an SLL with shamt=10 -> busy=0, done=0, data_out=0 immediately; no done pulse afterwards.
- Restart after reset: next start (op=001, shamt=1, data_in=1) -> data_out=2.
- Protocol: start held high through a whole 5-cycle op -> second operation accepted only after return to IDLE; data_in changed mid-shift has no effect on the result.

Source files
------------

// File: rtl/seq_shifter_pkg.sv
// Shared constants, op codes and state encoding for the
// multicycle shift unit.
package shifter_pkg;

    localparam int DATA_W  = 32;
    localparam int SHAMT_W = 6;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SRA  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Codes 110/111 behave as PASS, so only 001..101 iterate.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Control-unit handshake and operand/result bus of the
// multicycle shift unit.
interface seq_shifter_if;
    import shifter_pkg::*;

    logic               start;
    logic [2:0]         op;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  data_in;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  data_out;

    modport master (
        output start,
        output op,
        output shamt,
        output data_in,
        input  busy,
        input  done,
        input  data_out
    );

    modport slave (
        input  start,
        input  op,
        input  shamt,
        input  data_in,
        output busy,
        output done,
        output data_out
    );

endinterface

// File: rtl/seq_shifter_shift_step.sv
// One-bit shift or rotate of a word, selected by op code;
// unknown or PASS codes return the word unchanged.
module shift_step
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_SLL: o_data = {i_data[DATA_W-2:0], 1'b0};
            OP_SRL: o_data = {1'b0, i_data[DATA_W-1:1]};
            OP_SRA: o_data = {i_data[DATA_W-1], i_data[DATA_W-1:1]};
            OP_ROL: o_data = {i_data[DATA_W-2:0], i_data[DATA_W-1]};
            OP_ROR: o_data = {i_data[0], i_data[DATA_W-1:1]};
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multicycle shift unit: captures an operand on start and
// shifts it one bit per clock, pulsing done with the result.
module seq_shifter
    import shifter_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    seq_shifter_if.slave bus
);

    state_t             r_state;
    state_t             w_next;
    logic [DATA_W-1:0]  r_work;
    logic [DATA_W-1:0]  r_data_out;
    logic [DATA_W-1:0]  w_step;
    logic [SHAMT_W-1:0] r_count;
    logic [2:0]         r_op;
    logic               w_accept;
    logic               w_direct;
    logic               w_last;

    assign w_accept = (r_state == ST_IDLE) && bus.start;
    assign w_direct = (bus.shamt == '0) || !is_shift_op(bus.op);
    assign w_last   = (r_count == SHAMT_W'(1));

    shift_step u_step (
        .i_data (r_work),
        .i_op   (r_op),
        .o_data (w_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next = w_direct ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Result register only moves on entry to DONE, so the
    // previous result stays visible throughout SHIFT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_work     <= '0;
            r_count    <= '0;
            r_op       <= OP_PASS;
            r_data_out <= '0;
        end else if (w_accept) begin
            r_work  <= bus.data_in;
            r_op    <= bus.op;
            r_count <= w_direct ? '0 : bus.shamt;
            if (w_direct) begin
                r_data_out <= bus.data_in;
            end
        end else if (r_state == ST_SHIFT) begin
            r_work  <= w_step;
            r_count <= r_count - 1'b1;
            if (w_last) begin
                r_data_out <= w_step;
            end
        end
    end

    assign bus.busy     = (r_state == ST_SHIFT);
    assign bus.done     = (r_state == ST_DONE);
    assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: latency, busy width,
// results, reset abort and start-protocol behaviour.
module tb_seq_shifter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] last = 32'h0;

    seq_shifter_if sif ();

    seq_shifter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [5:0] sh, input logic [31:0] din,
                          input logic [31:0] exp, input int lat);
        int n;
        int bc;
        sif.start = 1'b1;
        sif.op = op;
        sif.shamt = sh;
        sif.data_in = din;
        tick();
        sif.start = 1'b0;
        sif.op = 3'b001;
        sif.shamt = 6'd7;
        sif.data_in = ~din;
        n = 0;
        bc = 0;
        while (sif.done !== 1'b1 && n < 100) begin
            if (sif.busy === 1'b1) begin
                bc++;
                if (bc == 1) chk({tag, "_hold"}, sif.data_out, last);
            end
            tick();
            n++;
        end
        chk({tag, "_done"}, 32'(sif.done), 32'd1);
        chk({tag, "_busy_at_done"}, 32'(sif.busy), 32'd0);
        chk({tag, "_lat"}, 32'(n), 32'(lat));
        chk({tag, "_busycnt"}, 32'(bc), 32'(lat));
        chk({tag, "_out"}, sif.data_out, exp);
        last = exp;
        tick();
        chk({tag, "_pulse"}, 32'(sif.done), 32'd0);
        chk({tag, "_keep"}, sif.data_out, exp);
    endtask

    initial begin
        int seen;
        sif.start = 1'b0;
        sif.op = 3'b000;
        sif.shamt = 6'd0;
        sif.data_in = 32'h0;
        tick();
        tick();
        chk("rst_busy", 32'(sif.busy), 32'd0);
        chk("rst_done", 32'(sif.done), 32'd0);
        chk("rst_out", sif.data_out, 32'h0);
        reset = 1'b1;
        tick();

        run_op("sll4", 3'b001, 6'd4, 32'h0000_00F1, 32'h0000_0F10, 4);
        run_op("sra16", 3'b011, 6'd16, 32'h8000_1234, 32'hFFFF_8000, 16);
        run_op("srl40", 3'b010, 6'd40, 32'hFFFF_FFFF, 32'h0, 40);
        run_op("ror33", 3'b101, 6'd33, 32'h0000_0001, 32'h8000_0000, 33);
        run_op("rol33", 3'b100, 6'd33, 32'h8000_0001, 32'h0000_0003, 33);
        run_op("sra40", 3'b011, 6'd40, 32'h8000_0000, 32'hFFFF_FFFF, 40);
        run_op("sll32", 3'b001, 6'd32, 32'hFFFF_FFFF, 32'h0, 32);
        run_op("sh0", 3'b001, 6'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);
        run_op("op7", 3'b111, 6'd5, 32'h1234_5678, 32'h1234_5678, 0);
        run_op("pass", 3'b000, 6'd9, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0);

        // Abort an SLL by 10 two cycles in.
        sif.start = 1'b1;
        sif.op = 3'b001;
        sif.shamt = 6'd10;
        sif.data_in = 32'h0000_0001;
        tick();
        sif.start = 1'b0;
        tick();
        tick();
        chk("abort_busy_pre", 32'(sif.busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(sif.busy), 32'd0);
        chk("abort_done", 32'(sif.done), 32'd0);
        chk("abort_out", sif.data_out, 32'h0);
        tick();
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (sif.done === 1'b1 || sif.busy === 1'b1) seen++;
        end
        chk("abort_nopulse", 32'(seen), 32'd0);
        last = 32'h0;
        run_op("restart", 3'b001, 6'd1, 32'h0000_0001, 32'h0000_0002, 1);

        // Start held high across a whole op, inputs changed mid-shift.
        sif.start = 1'b1;
        sif.op = 3'b001;
        sif.shamt = 6'd4;
        sif.data_in = 32'h0000_0001;
        tick();
        sif.op = 3'b010;
        sif.shamt = 6'd2;
        sif.data_in = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) tick();
        chk("hold_done", 32'(sif.done), 32'd1);
        chk("hold_out", sif.data_out, 32'h0000_0010);
        tick();
        chk("hold_idle_busy", 32'(sif.busy), 32'd0);
        chk("hold_idle_done", 32'(sif.done), 32'd0);
        tick();
        sif.start = 1'b0;
        chk("hold_second_busy", 32'(sif.busy), 32'd1);
        chk("hold_second_keep", sif.data_out, 32'h0000_0010);
        tick();
        tick();
        chk("hold_second_done", 32'(sif.done), 32'd1);
        chk("hold_second_out", sif.data_out, 32'h3FFF_C000);
        tick();
        chk("hold_second_pulse", 32'(sif.done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
